instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the program counter, drives address/enable into the combinational instruction ROM, and registers the returned word into an instruction register for decode.
- Supports stall (hold), redirect (branch/jump target load with flush), and automatic halt once the last programmed address has been issued.
- Sits between the ROM and the decode/control stage of the single-cycle datapath.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- END_PC, 32'h20, last valid instruction address. Fetching stops after this word is issued.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  32  address to ROM. Combinational copy of the pc register.
- rom_en  out  1  ROM enable. 1 only in state FETCH.
- rom_data  in  32  ROM output word, valid in the same cycle as rom_addr.
- stall  in  1  hold: no PC advance, outputs unchanged.
- redirect_valid  in  1  load redirect_target into the PC and flush.
- redirect_target  in  32  new PC. Bits [1:0] are forced to 0.
- instr_valid  out  1  instr_out/instr_pc hold a valid fetched instruction.
- instr_out  out  32  registered instruction word.
- instr_pc  out  32  address instr_out was fetched from.
- halted  out  1  1 while in state HALT.

Behaviour:
- One clock domain. All state changes on the rising clk edge. reset is sampled only at the edge.
- Reset values: pc=RESET_PC, state=IDLE, instr_valid=0, instr_out=0, instr_pc=0, halted=0, rom_en=0.
- States are IDLE, FETCH and HALT.
- IDLE: lasts exactly one cycle after reset deasserts, then moves to FETCH. No fetch occurs. rom_en=0.
- FETCH, rom_en=1. Priority per cycle is reset > redirect_valid > stall > normal.
  - redirect_valid=1: pc <= {redirect_target[31:2],2'b00}. instr_valid <= 0 (flush). instr_out and instr_pc hold. Stays in FETCH. The same-cycle stall is ignored.
  - stall=1, no redirect: pc, instr_out, instr_pc and instr_valid all hold.
  - Normal: instr_out <= rom_data, instr_pc <= pc, instr_valid <= 1, pc <= pc+4.
    - pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
    - If pc == END_PC, the state goes to HALT and pc still increments.
- Fetch latency: the word at address A appears on instr_out one edge after the FETCH cycle in which pc==A.
- HALT: rom_en=0 and halted=1.
  - The first HALT cycle still shows the END_PC instruction with instr_valid=1 (it was registered on the transition edge). instr_valid <= 0 on the next edge.
  - stall is ignored in HALT.
  - redirect_valid=1 loads the PC (aligned) and returns to FETCH with instr_valid=0 and halted=0.
- Outside [RESET_PC..END_PC]: if a redirect targets an address > END_PC, the word is still fetched (ROM contents are don't-care). The halt check is equality only (pc==END_PC). No error flag.
- Misaligned redirect_target: low two bits are silently cleared, e.g. 32'h0000000E becomes 32'h0000000C.
- Reset mid-operation: on an edge with reset=1, all registers take their reset values regardless of state, stall or redirect.
- rom_addr always equals the pc register, including in IDLE and HALT.

Test Plan:
- Reset then free-run, ROM[0x0]=32'h00300093, ROM[0x4]=32'h00700113 -> cycle after IDLE: rom_addr=0, rom_en=1; next edge instr_out=32'h00300093, instr_pc=0, instr_valid=1; following edge instr_out=32'h00700113, instr_pc=4.
- Stall for 3 cycles while pc=0x8 -> pc stays 0x8, instr_out/instr_pc/instr_valid unchanged for all 3 cycles; on release the 0x8 word is captured and pc=0xC.
- redirect_valid with redirect_target=32'h0000001E and stall=1 in the same cycle -> pc=0x1C next edge, instr_valid=0 that cycle; following edge instr_pc=0x1C, instr_valid=1.
- Run to END_PC=0x20 -> 0x20 word captured with instr_valid=1, halted=1, rom_en=0; next cycle instr_valid=0; pc remains 0x24 indefinitely with stall toggling.
- In HALT, assert redirect_valid with target 0x4 -> halted=0, rom_en=1, pc=0x4; the 0x4 word is fetched on the following edge.
- Assert reset while in FETCH at pc=0x14 with redirect_valid=1 -> next edge pc=RESET_PC, state IDLE, instr_valid=0, instr_out=0, halted=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational ROM, and registers each word with its PC one edge after issue.
// A stall holds PC and outputs; a redirect reloads the PC and flushes the output word. Fetching halts after END_PC is issued.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] END_PC   = 32'h20
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    output logic        rom_en,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] redirect_pc;

    // Targets are word addresses; the byte offset is dropped without complaint.
    assign redirect_pc = redirect_target & ~32'h3;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                end else if (!stall) begin
                    instr_out_d   = rom_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    if (pc_q == END_PC) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                // The END_PC word is shown for exactly one HALT cycle.
                instr_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_out_q   <= 32'h0;
            instr_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign rom_addr    = pc_q;
    assign rom_en      = (state_q == ST_FETCH);
    assign halted      = (state_q == ST_HALT);
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic against a behavioural model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] END_PC   = 32'h20;

    logic        clk;
    logic        reset;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = idle, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_out;
    logic [31:0] m_ipc;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .END_PC  (END_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_data       (rom_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h00300093;
        if (a == 32'h4) return 32'h00700113;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rom_addr"},    rom_addr,           m_pc);
        chk({tag, ".rom_en"},      {31'b0, rom_en},    {31'b0, m_mode == 1});
        chk({tag, ".halted"},      {31'b0, halted},    {31'b0, m_mode == 2});
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
        chk({tag, ".instr_out"},   instr_out,          m_out);
        chk({tag, ".instr_pc"},    instr_pc,           m_ipc);
    endtask

    // Apply one cycle of inputs, advance the model, clock, then check everything.
    task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rt, input string tag);
        reset           = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        if (r) begin
            m_mode = 0; m_pc = RESET_PC; m_valid = 1'b0; m_out = 32'h0; m_ipc = 32'h0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rv) begin
                m_pc = rt - (rt % 4);
                m_valid = 1'b0;
            end else if (!s) begin
                m_out = rom_fn(m_pc);
                m_ipc = m_pc;
                m_valid = 1'b1;
                if (m_pc == END_PC) m_mode = 2;
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_valid = 1'b0;
            if (rv) begin
                m_pc = rt - (rt % 4);
                m_mode = 1;
            end
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        m_mode = 0; m_pc = RESET_PC; m_valid = 1'b0; m_out = 32'h0; m_ipc = 32'h0;
        @(posedge clk); #1;

        // Reset state
        cyc(1, 0, 0, 32'h0, "reset0");
        cyc(1, 1, 1, 32'h40, "reset1");
        chk("reset.rom_en", {31'b0, rom_en}, 32'h0);
        chk("reset.pc", rom_addr, RESET_PC);

        // One idle cycle, then fetching
        cyc(0, 0, 0, 32'h0, "idle");
        chk("first.rom_en", {31'b0, rom_en}, 32'h1);
        chk("first.rom_addr", rom_addr, 32'h0);
        chk("first.valid", {31'b0, instr_valid}, 32'h0);
        cyc(0, 0, 0, 32'h0, "f0");
        chk("f0.word", instr_out, 32'h00300093);
        chk("f0.pc", instr_pc, 32'h0);
        cyc(0, 0, 0, 32'h0, "f4");
        chk("f4.word", instr_out, 32'h00700113);
        chk("f4.pc", instr_pc, 32'h4);

        // Stall three cycles at pc 0x8
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, "stall");
        chk("stall.pc", rom_addr, 32'h8);
        chk("stall.ipc", instr_pc, 32'h4);
        cyc(0, 0, 0, 32'h0, "release");
        chk("release.ipc", instr_pc, 32'h8);
        chk("release.pc", rom_addr, 32'hC);

        // Misaligned redirect with simultaneous stall
        cyc(0, 1, 1, 32'h0000001E, "redir");
        chk("redir.pc", rom_addr, 32'h1C);
        chk("redir.valid", {31'b0, instr_valid}, 32'h0);
        cyc(0, 0, 0, 32'h0, "redir_f");
        chk("redir_f.ipc", instr_pc, 32'h1C);
        chk("redir_f.valid", {31'b0, instr_valid}, 32'h1);

        // Reach END_PC and halt
        cyc(0, 0, 0, 32'h0, "end");
        chk("end.ipc", instr_pc, 32'h20);
        chk("end.halted", {31'b0, halted}, 32'h1);
        chk("end.valid", {31'b0, instr_valid}, 32'h1);
        chk("end.rom_en", {31'b0, rom_en}, 32'h0);
        for (int i = 0; i < 6; i++) cyc(0, logic'(i % 2), 0, 32'h0, "halt");
        chk("halt.valid", {31'b0, instr_valid}, 32'h0);
        chk("halt.pc", rom_addr, 32'h24);

        // Leave halt via redirect
        cyc(0, 0, 1, 32'h4, "unhalt");
        chk("unhalt.halted", {31'b0, halted}, 32'h0);
        chk("unhalt.pc", rom_addr, 32'h4);
        cyc(0, 0, 0, 32'h0, "unhalt_f");
        chk("unhalt_f.word", instr_out, 32'h00700113);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, "run14");
        chk("run14.pc", rom_addr, 32'h14);

        // Reset wins over redirect mid-fetch
        cyc(1, 0, 1, 32'h40, "midreset");
        chk("midreset.out", instr_out, 32'h0);
        chk("midreset.pc", rom_addr, RESET_PC);
        cyc(0, 0, 0, 32'h0, "post_reset");

        // PC wrap-around at the top of the address space
        cyc(0, 0, 1, 32'hFFFFFFFF, "wrap_redir");
        chk("wrap_redir.pc", rom_addr, 32'hFFFFFFFC);
        cyc(0, 0, 0, 32'h0, "wrap");
        chk("wrap.pc", rom_addr, 32'h0);
        chk("wrap.ipc", instr_pc, 32'hFFFFFFFC);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, s, rv;
            logic [31:0] t;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 'h30));
            cyc(r, s, rv, t, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
